// File: rtl/tm1638_key_reader_if.sv
// Signal bundle between a host and the TM1638 key-scan reader.
// slave: the reader itself; master: the host/board side (request and DIO pad readback).
interface tm1638_key_reader_if;
   logic        req;
   logic        dio_in;
   logic        stb;
   logic        clk_kHz;
   logic        dio_out;
   logic        dio_oe;
   logic        busy;
   logic [31:0] keys;
   logic        valid;
   logic        any_key;

   modport slave (
      input  req, dio_in,
      output stb, clk_kHz, dio_out, dio_oe, busy, keys, valid, any_key
   );

   modport master (
      output req, dio_in,
      input  stb, clk_kHz, dio_out, dio_oe, busy, keys, valid, any_key
   );
endinterface

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: on req, sends the read-keys command (0x42), releases DIO
// for a turnaround gap, clocks in 32 key bits LSB first, then publishes them on keys.
// Optional macro TM1638_KEY_DEBOUNCE_EN: keys only update when two consecutive raw
// scans match; valid still pulses at every frame end.
module tm1638_key_reader #(
   parameter int unsigned CLK_DIV     = 50,
   parameter int unsigned WAIT_CYCLES = 200
) (
   input  logic                 clk,
   input  logic                 rst,
   tm1638_key_reader_if.slave   bus
);

   typedef enum logic [2:0] {IDLE, CMD, TURN, READ, STOP} state_t;

   localparam logic [7:0]  CMD_BYTE  = 8'h42;
   localparam logic [9:0]  DIV_LAST  = 10'(CLK_DIV - 1);
   localparam logic [11:0] WAIT_LAST = 12'(WAIT_CYCLES - 1);

   state_t      state, state_nx;
   logic [9:0]  div_cnt;
   logic        ph;          // 0 = serial clock low half, 1 = high half
   logic [4:0]  bit_cnt;
   logic [11:0] wait_cnt;
   logic [31:0] shift_q;
   logic [31:0] keys_q;
   logic        valid_q;
   logic        any_q;

   logic div_end, bit_end, sample, frame_done, take;

   assign div_end    = (div_cnt == DIV_LAST);
   assign bit_end    = div_end && ph;
   assign sample     = (state == READ) && ph && (div_cnt == '0);
   assign frame_done = (state == STOP) && div_end;

`ifdef TM1638_KEY_DEBOUNCE_EN
   logic [31:0] prev_q;

   // Remember the previous raw scan so a new one is accepted only if it repeats.
   always_ff @(posedge clk) begin
      if (!rst)           prev_q <= '0;
      else if (frame_done) prev_q <= shift_q;
   end

   assign take = (shift_q == prev_q);
`else
   assign take = 1'b1;
`endif

   // Next-state decode for the frame sequencer.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.req)                       state_nx = CMD;
         CMD:     if (bit_end && bit_cnt == 5'd7)    state_nx = TURN;
         TURN:    if (wait_cnt == WAIT_LAST)         state_nx = READ;
         READ:    if (bit_end && bit_cnt == 5'd31)   state_nx = STOP;
         STOP:    if (div_end)                       state_nx = IDLE;
         default:                                    state_nx = IDLE;
      endcase
   end

   // State register plus bit/phase/wait counters; all counters reload on a state change.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         div_cnt  <= '0;
         ph       <= 1'b0;
         bit_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state_nx != state) begin
            div_cnt  <= '0;
            ph       <= 1'b0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
         end else begin
            case (state)
               CMD, READ: begin
                  if (div_end) begin
                     div_cnt <= '0;
                     ph      <= ~ph;
                     if (ph) bit_cnt <= bit_cnt + 5'd1;
                  end else begin
                     div_cnt <= div_cnt + 10'd1;
                  end
               end
               TURN:    wait_cnt <= wait_cnt + 12'd1;
               STOP:    div_cnt  <= div_cnt + 10'd1;
               default: ;
            endcase
         end
      end
   end

   // Capture DIO on the first cycle of each serial-clock high half, LSB first.
   always_ff @(posedge clk) begin
      if (!rst)        shift_q <= '0;
      else if (sample) shift_q <= {bus.dio_in, shift_q[31:1]};
   end

   // Publish the scan and the completion pulse as IDLE is re-entered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         keys_q  <= '0;
         any_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= frame_done;
         if (frame_done && take) begin
            keys_q <= shift_q;
            any_q  <= |shift_q;
         end
      end
   end

   assign bus.stb     = (state == IDLE);
   assign bus.clk_kHz = (state == CMD || state == READ) ? ph : 1'b1;
   assign bus.dio_oe  = (state == CMD);
   assign bus.dio_out = (state == CMD) ? CMD_BYTE[bit_cnt[2:0]] : 1'b0;
   assign bus.busy    = (state != IDLE) || valid_q;
   assign bus.keys    = keys_q;
   assign bus.valid   = valid_q;
   assign bus.any_key = any_q;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Directed bench for tm1638_key_reader with a small TM1638 chip model on DIO.
module tb_tm1638_key_reader;
   localparam int unsigned CLK_DIV     = 2;
   localparam int unsigned WAIT_CYCLES = 4;
   localparam int VALID_CYC = 167;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   tm1638_key_reader_if bus();

   tm1638_key_reader #(.CLK_DIV(CLK_DIV), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Chip model: count serial-clock falls within a frame; falls 9..40 carry read bits.
   logic [31:0] model_data = '0;
   logic [7:0]  cmd_seen   = '0;
   int          fall_cnt   = 0;
   int          oe_clash   = 0;

   always @(negedge bus.clk_kHz) fall_cnt = fall_cnt + 1;
   always @(posedge bus.stb)     fall_cnt = 0;

   always_comb begin
      bus.dio_in = 1'b1;
      if (fall_cnt >= 9 && fall_cnt <= 40) bus.dio_in = model_data[5'(fall_cnt - 9)];
   end

   always @(posedge bus.clk_kHz)
      if (fall_cnt >= 1 && fall_cnt <= 8) cmd_seen[3'(fall_cnt - 1)] = bus.dio_out;

   always @(negedge clk)
      if (fall_cnt >= 9 && !bus.stb && bus.dio_oe) oe_clash = oe_clash + 1;

   // Expected keys after a completed frame.
   logic [31:0] exp_keys = '0;
`ifdef TM1638_KEY_DEBOUNCE_EN
   logic [31:0] exp_prev = '0;
`endif

   task automatic predict(input logic [31:0] scan);
`ifdef TM1638_KEY_DEBOUNCE_EN
      if (scan == exp_prev) exp_keys = scan;
      exp_prev = scan;
`else
      exp_keys = scan;
`endif
   endtask

   task automatic model_reset();
      exp_keys = '0;
`ifdef TM1638_KEY_DEBOUNCE_EN
      exp_prev = '0;
`endif
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One request pulse, then observe up to 260 cycles; optional stray reqs at cycles 5 and 50.
   task automatic run_frame(input logic [31:0] data, input bit poke,
                            output int vcyc, output int vcount,
                            output logic [31:0] vkeys, output logic vany, output logic busy_after);
      model_data = data;
      vcyc = 0; vcount = 0; vkeys = '0; vany = 1'b0; busy_after = 1'bx;
      @(negedge clk); bus.req = 1'b1;
      for (int cyc = 1; cyc <= 260; cyc++) begin
         @(negedge clk);
         bus.req = poke && (cyc == 5 || cyc == 50);
         if (cyc == 1) begin
            check("c1_stb", 32'(bus.stb), 32'd0);
            check("c1_dio_oe", 32'(bus.dio_oe), 32'd1);
            check("c1_busy", 32'(bus.busy), 32'd1);
         end
         if (bus.valid) begin
            vcount++;
            if (vcount == 1) begin
               vcyc = cyc; vkeys = bus.keys; vany = bus.any_key;
            end
         end
         if (vcyc != 0 && cyc == vcyc + 1) busy_after = bus.busy;
      end
      bus.req = 1'b0;
   endtask

   int          vcyc, vcount;
   logic [31:0] vkeys;
   logic        vany, busy_after;
   logic [7:0]  db_data [3];
   logic [7:0]  db_exp  [3];
   int          nval, run, nruns, bad_runs;
   bit          started;

   initial begin
      bus.req = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_stb", 32'(bus.stb), 32'd1);
      check("rst_clk_kHz", 32'(bus.clk_kHz), 32'd1);
      check("rst_dio_oe", 32'(bus.dio_oe), 32'd0);
      check("rst_dio_out", 32'(bus.dio_out), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_keys", bus.keys, 32'd0);
      check("rst_any", 32'(bus.any_key), 32'd0);
      rst = 1'b1;

      // Single frame, bytes 01,00,00,80
      run_frame(32'h8000_0001, 1'b0, vcyc, vcount, vkeys, vany, busy_after);
      predict(32'h8000_0001);
      check("cmd_byte", 32'(cmd_seen), 32'h42);
      check("valid_cycle", 32'(vcyc), 32'(VALID_CYC));
      check("valid_count", 32'(vcount), 32'd1);
      check("keys_8000_0001", vkeys, exp_keys);
      check("any_8000_0001", 32'(vany), 32'(|exp_keys));
      check("busy_after_valid", 32'(busy_after), 32'd0);

      // All-zero scan
      cmd_seen = '0;
      run_frame(32'h0, 1'b0, vcyc, vcount, vkeys, vany, busy_after);
      predict(32'h0);
      check("cmd_byte_2", 32'(cmd_seen), 32'h42);
      check("zero_valid_cycle", 32'(vcyc), 32'(VALID_CYC));
      check("zero_valid_count", 32'(vcount), 32'd1);
      check("zero_keys", vkeys, exp_keys);
      check("zero_any", 32'(vany), 32'(|exp_keys));
      check("zero_busy_168", 32'(busy_after), 32'd0);

      // Requests during a frame are ignored
      run_frame(32'h00C3_0010, 1'b1, vcyc, vcount, vkeys, vany, busy_after);
      predict(32'h00C3_0010);
      check("poke_valid_count", 32'(vcount), 32'd1);
      check("poke_valid_cycle", 32'(vcyc), 32'(VALID_CYC));
      check("poke_keys", vkeys, exp_keys);

      // Prime keys non-zero regardless of debounce, then abort a frame in READ bit 10
      run_frame(32'h00C3_0010, 1'b0, vcyc, vcount, vkeys, vany, busy_after);
      predict(32'h00C3_0010);
      check("prime_keys", vkeys, 32'h00C3_0010);
      model_data = 32'hFFFF_FFFF;
      @(negedge clk); bus.req = 1'b1;
      @(negedge clk); bus.req = 1'b0;            // cycle 1
      repeat (77) @(negedge clk);                // cycle 78, READ bit 10
      check("abort_in_read_clk", 32'(bus.stb), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      check("abort_stb", 32'(bus.stb), 32'd1);
      check("abort_clk_kHz", 32'(bus.clk_kHz), 32'd1);
      check("abort_dio_oe", 32'(bus.dio_oe), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_keys", bus.keys, 32'd0);
      check("abort_any", 32'(bus.any_key), 32'd0);
      vcount = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (bus.valid) vcount++;
      end
      check("abort_no_valid", 32'(vcount), 32'd0);
      run_frame(32'h1234_5678, 1'b0, vcyc, vcount, vkeys, vany, busy_after);
      predict(32'h1234_5678);
      check("post_abort_valid_cycle", 32'(vcyc), 32'(VALID_CYC));
      check("post_abort_keys", vkeys, exp_keys);

      // Debounce sequence A5, 5A, 5A from a fresh reset
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      model_reset();
      db_data[0] = 8'hA5; db_data[1] = 8'h5A; db_data[2] = 8'h5A;
`ifdef TM1638_KEY_DEBOUNCE_EN
      db_exp[0] = 8'h00; db_exp[1] = 8'h00; db_exp[2] = 8'h5A;
`else
      db_exp[0] = 8'hA5; db_exp[1] = 8'h5A; db_exp[2] = 8'h5A;
`endif
      for (int i = 0; i < 3; i++) begin
         run_frame({24'h0, db_data[i]}, 1'b0, vcyc, vcount, vkeys, vany, busy_after);
         predict({24'h0, db_data[i]});
         check($sformatf("db_scan%0d_keys", i), 32'(vkeys[7:0]), 32'(db_exp[i]));
         check($sformatf("db_scan%0d_valid", i), 32'(vcount), 32'd1);
      end

      // req held high: three frames, one stb-high cycle between them
      model_data = 32'h0F00_00F0;
      nval = 0; run = 0; nruns = 0; bad_runs = 0; started = 1'b0;
      @(negedge clk); bus.req = 1'b1;
      for (int c = 0; c < 700 && nval < 3; c++) begin
         @(negedge clk);
         if (bus.valid) begin
            nval++;
            predict(model_data);
            check($sformatf("b2b_keys%0d", nval), bus.keys, exp_keys);
            if (nval == 3) bus.req = 1'b0;
         end
         if (!bus.stb) begin
            started = 1'b1;
            if (run > 0) begin
               nruns++;
               if (run != 1) bad_runs++;
               run = 0;
            end
         end else if (started) begin
            run++;
         end
      end
      bus.req = 1'b0;
      check("b2b_frames", 32'(nval), 32'd3);
      check("b2b_gaps", 32'(nruns), 32'd2);
      check("b2b_gap_len", 32'(bad_runs), 32'd0);
      repeat (3) @(negedge clk);
      check("b2b_idle_stb", 32'(bus.stb), 32'd1);
      check("b2b_idle_busy", 32'(bus.busy), 32'd0);
      check("dio_contention", 32'(oe_clash), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tm1638_key_reader.md
TM1638_KEY_READER -- requirements
Module: tm1638_key_reader

Interface
REQ-001 Parameter CLK_DIV, default 50: half-period of the serial clock clk_kHz, in clk cycles; legal range 1..1023.
REQ-002 Parameter WAIT_CYCLES, default 200: clk cycles of DIO turnaround between command byte and first read bit; legal range 1..4095.
REQ-003 clk  input  1  system clock; all logic on posedge clk, single clock domain.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 req  input  1  scan request; sampled only in IDLE.
REQ-006 dio_in  input  1  TM1638 DIO read back from pad; already synchronised externally.
REQ-007 stb  output  1  TM1638 strobe, active-low frame select.
REQ-008 clk_kHz  output  1  TM1638 serial clock; idles high.
REQ-009 dio_out  output  1  TM1638 DIO drive value, meaningful only while dio_oe=1.
REQ-010 dio_oe  output  1  DIO output enable; 1 = block drives pad, 0 = pad released to TM1638.
REQ-011 busy  output  1  high from the cycle after req acceptance until the cycle valid pulses, inclusive.
REQ-012 keys  output  32  key-scan bytes; byte0 = keys[7:0] = first byte read, each byte LSB first.
REQ-013 valid  output  1  one-cycle pulse marking completion of a scan.
REQ-014 any_key  output  1  OR-reduction of keys; registered with keys.

Function
REQ-015 States: IDLE, CMD, TURN, READ, STOP; every state other than IDLE holds busy=1.
REQ-016 IDLE: stb=1, clk_kHz=1, dio_oe=0; req=1 -> CMD next cycle; req=0 -> stay.
REQ-017 Request accepted at cycle 0 -> stb=0 and dio_oe=1 from cycle 1.
REQ-018 CMD: shift out 8'h42 LSB first; per bit, clk_kHz low for CLK_DIV cycles then high for CLK_DIV cycles; dio_out updated on the cycle clk_kHz falls.
REQ-019 After 8 bits (16*CLK_DIV cycles), CMD -> TURN with dio_oe=0, clk_kHz=1, stb=0.
REQ-020 TURN lasts exactly WAIT_CYCLES cycles, then -> READ.
REQ-021 READ: 32 bits with the same bit timing as CMD; dio_in sampled in the cycle clk_kHz goes 0->1; bits shifted into a 32-bit register LSB first.
REQ-022 After 32 bits (64*CLK_DIV cycles), READ -> STOP; STOP holds stb=0, clk_kHz=1 for CLK_DIV cycles, then -> IDLE.
REQ-023 On the cycle IDLE is re-entered, stb=1 and keys/any_key update, with valid=1 for that single cycle.
REQ-024 valid at cycle 1 + 81*CLK_DIV + WAIT_CYCLES after acceptance; busy falls the cycle after valid.
REQ-025 req is ignored while busy=1; no queueing.
REQ-026 req held high continuously -> back-to-back scans with one IDLE cycle between frames.
REQ-027 The bit counter and the CLK_DIV and WAIT_CYCLES counters saturate at terminal count and reload; no wrap-around into an extra bit.
REQ-028 dio_oe=1 only in CMD; outside CMD, dio_out=0.

Reset
REQ-029 rst=0 at any clock edge, including mid-frame: next cycle state=IDLE, stb=1, clk_kHz=1, dio_oe=0, dio_out=0, busy=0, valid=0, keys=0, any_key=0, and all counters and the shift register = 0.
REQ-030 A frame aborted by reset produces no valid pulse and leaves keys unchanged from its reset value.

Configuration
REQ-031 Macro TM1638_KEY_DEBOUNCE_EN defined: at frame end keys updates only when the new 32-bit scan equals the previous raw scan; a previous-scan register is added and cleared by reset; valid pulses at every frame end regardless.
REQ-032 Macro TM1638_KEY_DEBOUNCE_EN undefined: keys updates at every frame end; no previous-scan register exists.

Verification (CLK_DIV=2, WAIT_CYCLES=4)
REQ-033 Single req pulse, TM1638 model returns bytes 01,00,00,80 -> command bits on dio_out = 0,1,0,0,0,0,1,0; valid at cycle 167; keys=32'h8000_0001; any_key=1.
REQ-034 Model returns all zeros -> keys=0, any_key=0, valid pulses once, busy low at cycle 168.
REQ-035 req asserted at cycles 5 and 50 during a frame -> exactly one frame and one valid pulse.
REQ-036 rst=0 during READ bit 10 -> next cycle stb=1, clk_kHz=1, dio_oe=0, keys=0, no valid pulse; a later req yields a correct full frame.
REQ-037 TM1638_KEY_DEBOUNCE_EN defined, scans return A5, then 5A, then 5A in byte0 -> keys[7:0]=00, 00, 5A after scans 1, 2, 3; without the macro -> A5, 5A, 5A.
REQ-038 req held high for three frames -> stb high for exactly one cycle between frames; dio_oe never 1 while the model drives DIO.
